mtimer_wb: RTL and testbench

- RISC-V machine timer peripheral, a Wishbone slave on slave port MAIN_XBAR_MTIMER_SLAVE_IDX of the main crossbar.
- Decoded window: byte base 0xA000_0000, 16 bytes.
- Holds the 64-bit mtime counter and the 64-bit mtimecmp compare register.
- Drives the level-sensitive machine timer interrupt into the CPU.

---
 rtl/mtimer_wb_pkg.sv | 30 +++
 rtl/mtimer_wb_tick_gen.sv | 38 +++
 rtl/mtimer_wb.sv | 134 +++++++++++++
 tb/tb_mtimer_wb.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtimer_wb_pkg.sv
// Shared platform constants for the machine timer slave.
// Register offsets, reset values and bus request bundle.
package mtimer_wb_pkg;

  localparam int MAIN_WB_AW = 30;
  localparam int MAIN_WB_DW = 32;

  localparam int MAIN_XBAR_MTIMER_SLAVE_IDX = 3;

  localparam logic [31:0] MTIMER_BASE_ADDR = 32'hA000_0000;
  localparam logic [31:0] MTIMER_MASK      = 32'hFFFF_FFF0;

  localparam logic [1:0] MTIMER_MTIME_LO_OFF    = 2'd0;
  localparam logic [1:0] MTIMER_MTIME_HI_OFF    = 2'd1;
  localparam logic [1:0] MTIMER_MTIMECMP_LO_OFF = 2'd2;
  localparam logic [1:0] MTIMER_MTIMECMP_HI_OFF = 2'd3;

  localparam int MTIMER_PRESCALE = 1;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  off;
    logic [3:0]  sel;
    logic [31:0] dat;
  } mtimer_req_t;

endpackage

// File: rtl/mtimer_wb_tick_gen.sv
// Prescale counter for the machine timer.
// Emits a one-cycle tick every PRESCALE clocks.
module mtimer_tick_gen
  import mtimer_wb_pkg::*;
#(
  parameter int PRESCALE = MTIMER_PRESCALE
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == LAST);

  // Wrap to zero on the tick, else count up.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick_o) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mtimer_wb.sv
// RISC-V machine timer (mtime/mtimecmp) Wishbone slave.
// Level MTIP output, byte-granular writes, registered reads.
module mtimer_wb
  import mtimer_wb_pkg::*;
#(
  parameter int          AW           = MAIN_WB_AW,
  parameter int          DW           = MAIN_WB_DW,
  parameter int          PRESCALE     = MTIMER_PRESCALE,
  parameter logic [63:0] MTIMECMP_RST = mtimer_wb_pkg::MTIMECMP_RST
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_addr_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic [DW-1:0] wb_dat_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_stall_o,
  output logic          timer_irq_o
);

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] dat,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) begin
        r[b*8 +: 8] = dat[b*8 +: 8];
      end
    end
    return r;
  endfunction

  mtimer_req_t req;
  logic        tick;
  logic        unused_addr;

  logic [63:0] mtime_q;
  logic [63:0] mtime_d;
  logic [63:0] mtimecmp_q;
  logic [63:0] mtimecmp_d;
  logic [31:0] dat_q;
  logic [31:0] dat_d;
  logic [31:0] rd_word;
  logic        ack_q;
  logic        irq_q;

  assign unused_addr = ^wb_addr_i[AW-1:2];

  assign req.rd  = wb_cyc_i & wb_stb_i & ~wb_we_i;
  assign req.wr  = wb_cyc_i & wb_stb_i & wb_we_i;
  assign req.off = wb_addr_i[1:0];
  assign req.sel = wb_sel_i[3:0];
  assign req.dat = wb_dat_i[31:0];

  mtimer_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tick_o(tick)
  );

  // Select the addressed word from the current register values.
  always_comb begin
    rd_word = mtime_q[31:0];
    unique case (req.off)
      MTIMER_MTIME_LO_OFF:    rd_word = mtime_q[31:0];
      MTIMER_MTIME_HI_OFF:    rd_word = mtime_q[63:32];
      MTIMER_MTIMECMP_LO_OFF: rd_word = mtimecmp_q[31:0];
      MTIMER_MTIMECMP_HI_OFF: rd_word = mtimecmp_q[63:32];
      default:                rd_word = mtime_q[31:0];
    endcase
  end

  // mtime: bus write beats the tick, otherwise 64-bit increment.
  always_comb begin
    mtime_d = mtime_q;
    if (req.wr && req.off == MTIMER_MTIME_LO_OFF) begin
      mtime_d[31:0] = merge(mtime_q[31:0], req.dat, req.sel);
    end else if (req.wr && req.off == MTIMER_MTIME_HI_OFF) begin
      mtime_d[63:32] = merge(mtime_q[63:32], req.dat, req.sel);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  // mtimecmp: only bus writes change it.
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (req.wr && req.off == MTIMER_MTIMECMP_LO_OFF) begin
      mtimecmp_d[31:0] = merge(mtimecmp_q[31:0], req.dat, req.sel);
    end else if (req.wr && req.off == MTIMER_MTIMECMP_HI_OFF) begin
      mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], req.dat, req.sel);
    end
  end

  // Read data is captured on the accept edge and held otherwise.
  always_comb begin
    dat_d = dat_q;
    if (req.rd) begin
      dat_d = rd_word;
    end
  end

  // Timer state, bus response and interrupt registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RST;
      dat_q      <= '0;
      ack_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      dat_q      <= dat_d;
      ack_q      <= wb_cyc_i & wb_stb_i;
      irq_q      <= (mtime_q >= mtimecmp_q);
    end
  end

  assign wb_dat_o    = DW'(dat_q);
  assign wb_ack_o    = ack_q;
  assign wb_stall_o  = 1'b0;
  assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_mtimer_wb.sv
// Self-checking bench for mtimer_wb.
// Two instances: prescale 1 and prescale 4 on a shared bus.
module tb_mtimer_wb;

  logic        clk;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [29:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdat;

  logic [31:0] dat_o [2];
  logic        ack_o [2];
  logic        stall_o [2];
  logic        irq_o [2];

  int passed;
  int total;

  mtimer_wb #(.PRESCALE(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_addr_i(addr), .wb_sel_i(sel), .wb_dat_i(wdat),
    .wb_dat_o(dat_o[0]), .wb_ack_o(ack_o[0]),
    .wb_stall_o(stall_o[0]), .timer_irq_o(irq_o[0])
  );

  mtimer_wb #(.PRESCALE(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_addr_i(addr), .wb_sel_i(sel), .wb_dat_i(wdat),
    .wb_dat_o(dat_o[1]), .wb_ack_o(ack_o[1]),
    .wb_stall_o(stall_o[1]), .timer_irq_o(irq_o[1])
  );

  always #5 clk = ~clk;

  // Reference model: 64-bit values, tick on every PRESCALE-th clock.
  logic [63:0] m_mt [2];
  logic [63:0] m_cmp [2];
  logic [31:0] m_dat [2];
  logic        m_irq [2];
  logic        m_ack;
  int unsigned n_m;

  function automatic logic [63:0] put(
    input logic [63:0] old, input logic hi,
    input logic [31:0] d, input logic [3:0] s
  );
    logic [63:0] r;
    int base;
    r = old;
    base = hi ? 32 : 0;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[base + b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n_m   <= 0;
      m_ack <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        m_mt[p]  <= 64'd0;
        m_cmp[p] <= '1;
        m_dat[p] <= 32'd0;
        m_irq[p] <= 1'b0;
      end
    end else begin
      n_m   <= n_m + 1;
      m_ack <= cyc && stb;
      for (int p = 0; p < 2; p++) begin
        m_irq[p] <= (m_mt[p] >= m_cmp[p]);
        if (cyc && stb && !we)
          m_dat[p] <= addr[1]
            ? (addr[0] ? m_cmp[p][63:32] : m_cmp[p][31:0])
            : (addr[0] ? m_mt[p][63:32] : m_mt[p][31:0]);
        if (cyc && stb && we && !addr[1])
          m_mt[p] <= put(m_mt[p], addr[0], wdat, sel);
        else if ((n_m % ((p == 0) ? 1 : 4)) == ((p == 0) ? 0 : 3))
          m_mt[p] <= m_mt[p] + 64'd1;
        if (cyc && stb && we && addr[1])
          m_cmp[p] <= put(m_cmp[p], addr[0], wdat, sel);
      end
    end
  end

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Single transfer, entered and left at a negedge.
  task automatic xfer(input int d, input logic w, input logic [1:0] a,
                      input logic [3:0] s, input logic [31:0] dt,
                      output logic [31:0] rd);
    cyc  = 1'b1;
    stb  = 1'b1;
    we   = w;
    addr = {28'h0, a};
    sel  = s;
    wdat = dt;
    @(negedge clk);
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
    check($sformatf("ack d%0d a%0d", d, a), 64'(ack_o[d]), 64'd1);
    rd = dat_o[d];
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  a;
    logic [3:0]  s;
    logic [31:0] dt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [31:0] rd;
    int rise;
    passed = 0;
    total  = 0;
    clk = 1'b0; rst = 1'b1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    addr = '0; sel = '0; wdat = '0;

    vecs[0] = '{1'b1, 2'd2, 4'hF, 32'h1122_3344, 32'h0};
    vecs[1] = '{1'b0, 2'd2, 4'hF, 32'h0, 32'h1122_3344};
    vecs[2] = '{1'b1, 2'd2, 4'b0010, 32'hAABB_CCDD, 32'h0};
    vecs[3] = '{1'b0, 2'd2, 4'hF, 32'h0, 32'h1122_CC44};
    vecs[4] = '{1'b1, 2'd2, 4'b0000, 32'h0, 32'h0};
    vecs[5] = '{1'b0, 2'd2, 4'hF, 32'h0, 32'h1122_CC44};
    vecs[6] = '{1'b1, 2'd3, 4'b1001, 32'hA500_005A, 32'h0};
    vecs[7] = '{1'b0, 2'd3, 4'hF, 32'h0, 32'hA5FF_FF5A};
    vecs[8] = '{1'b1, 2'd3, 4'b0110, 32'h0012_3400, 32'h0};
    vecs[9] = '{1'b0, 2'd3, 4'hF, 32'h0, 32'hA512_345A};

    repeat (3) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      check("rst ack", 64'(ack_o[p]), 64'd0);
      check("rst dat", 64'(dat_o[p]), 64'd0);
      check("rst irq", 64'(irq_o[p]), 64'd0);
      check("rst stall", 64'(stall_o[p]), 64'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle irq", 64'(irq_o[0]), 64'd0);
    end
    xfer(0, 1'b0, 2'd0, 4'hF, 32'h0, rd);
    check("idle mtime lo", 64'(rd), 64'd10);
    xfer(0, 1'b0, 2'd1, 4'hF, 32'h0, rd);
    check("idle mtime hi", 64'(rd), 64'd0);
    xfer(0, 1'b0, 2'd2, 4'hF, 32'h0, rd);
    check("rst cmp lo", 64'(rd), 64'hFFFF_FFFF);
    xfer(0, 1'b0, 2'd3, 4'hF, 32'h0, rd);
    check("rst cmp hi", 64'(rd), 64'hFFFF_FFFF);

    xfer(0, 1'b1, 2'd0, 4'hF, 32'hFFFF_FFFE, rd);
    xfer(0, 1'b1, 2'd1, 4'hF, 32'h0, rd);
    repeat (3) @(negedge clk);
    xfer(0, 1'b0, 2'd1, 4'hF, 32'h0, rd);
    check("carry hi", 64'(rd), 64'd1);

    xfer(0, 1'b1, 2'd0, 4'hF, 32'h0, rd);
    xfer(0, 1'b1, 2'd1, 4'hF, 32'h0, rd);
    xfer(0, 1'b1, 2'd3, 4'hF, 32'h0, rd);
    xfer(0, 1'b1, 2'd2, 4'hF, 32'h40, rd);
    rise = -1;
    for (int k = 1; k <= 200 && rise < 0; k++) begin
      @(negedge clk);
      if (irq_o[0]) rise = k;
    end
    check("irq rise cycle", 64'(rise), 64'd63);
    xfer(0, 1'b1, 2'd3, 4'hF, 32'hFFFF_FFFF, rd);
    check("irq after hi wr", 64'(irq_o[0]), 64'd1);
    @(negedge clk);
    check("irq fall", 64'(irq_o[0]), 64'd0);
    xfer(0, 1'b1, 2'd2, 4'hF, 32'hFFFF_FFFF, rd);

    for (int i = 0; i < 10; i++) begin
      xfer(0, vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].dt, rd);
      if (!vecs[i].w)
        check($sformatf("vec%0d", i), 64'(rd), 64'(vecs[i].exp));
    end

    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("burst ack", 64'(ack_o[0]), 64'd1);
      check("burst stall", 64'(stall_o[0]), 64'd0);
      check("burst dat", 64'(dat_o[0]), 64'(m_dat[0]));
      if (i < 3) addr = 30'(i + 1);
      else begin cyc = 1'b0; stb = 1'b0; end
    end
    @(negedge clk);
    check("burst end ack", 64'(ack_o[0]), 64'd0);

    cyc = 1'b1; stb = 1'b1; addr = 30'd2;
    @(negedge clk);
    check("abort ack1", 64'(ack_o[0]), 64'd1);
    @(negedge clk);
    check("abort ack2", 64'(ack_o[0]), 64'd1);
    cyc = 1'b0;
    @(negedge clk);
    check("abort no ack", 64'(ack_o[0]), 64'd0);
    stb = 1'b0;

    xfer(1, 1'b1, 2'd1, 4'hF, 32'h0, rd);
    while ((n_m % 4) != 3) @(negedge clk);
    xfer(1, 1'b1, 2'd0, 4'hF, 32'h0, rd);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("presc k%0d", k), 64'(dat_o[1]), 64'((k - 1) / 4));
    end
    cyc = 1'b0; stb = 1'b0;

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        check($sformatf("rnd ack d%0d", p), 64'(ack_o[p]), 64'(m_ack));
        check($sformatf("rnd dat d%0d", p), 64'(dat_o[p]), 64'(m_dat[p]));
        check($sformatf("rnd irq d%0d", p), 64'(irq_o[p]), 64'(m_irq[p]));
      end
      cyc  = ($urandom % 4) != 0;
      stb  = $urandom % 2;
      we   = ($urandom % 3) == 0;
      addr = 30'($urandom);
      sel  = 4'($urandom);
      wdat = addr[0] ? 32'($urandom_range(0, 1)) : $urandom;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;

    @(negedge clk);
    xfer(0, 1'b1, 2'd2, 4'hF, 32'h0, rd);
    xfer(0, 1'b1, 2'd3, 4'hF, 32'h0, rd);
    @(negedge clk);
    @(negedge clk);
    check("pre-rst irq d0", 64'(irq_o[0]), 64'd1);
    check("pre-rst irq d1", 64'(irq_o[1]), 64'd1);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = '0;
    #2 rst = 1'b1;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    for (int p = 0; p < 2; p++) begin
      check("rst mid ack", 64'(ack_o[p]), 64'd0);
      check("rst mid irq", 64'(irq_o[p]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    xfer(0, 1'b0, 2'd0, 4'hF, 32'h0, rd);
    check("post-rst mtime", 64'(rd), 64'd0);
    check("post-rst irq", 64'(irq_o[0]), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
